mem_stage: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline; sits directly downstream of the E/M pipeline register and consumes its outputs.
- Contains the word-organised data memory with byte and halfword store merging, and load byte/halfword extraction with sign or zero extension.
- Includes the M/W pipeline register, so every output is registered and feeds the writeback stage.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_dm_ext.sv | 43 ++++
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory stage: MIPS load/store opcodes, the
// decoded memory-operation enum, and the opcode-to-operation decoder.
// The enum is shared by the stage, the load extender and the testbench.
package mem_stage_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [3:0] {
        NONE,
        LW,
        LB,
        LBU,
        LH,
        LHU,
        SW,
        SH,
        SB
    } mem_op_t;

    // Any opcode outside the eight load/store encodings is a non-memory op.
    function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
        mem_op_t op;
        case (opcode)
            OP_LW:   op = LW;
            OP_LB:   op = LB;
            OP_LBU:  op = LBU;
            OP_LH:   op = LH;
            OP_LHU:  op = LHU;
            OP_SW:   op = SW;
            OP_SH:   op = SH;
            OP_SB:   op = SB;
            default: op = NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_stage_dm_ext.sv
// dm_ext
// Purely combinational load lane select and sign/zero extension.
// Ports:
//   word    - 32-bit word read from data memory
//   addr_lo - low two bits of the byte address (lane 0 = bits [7:0])
//   mem_op  - decoded memory operation
//   data    - extended load result; 0 for anything that is not a load
module dm_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  mem_op_t     mem_op,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Pick the addressed halfword and byte up front, then extend by op type.
    // lw ignores the low address bits entirely.
    always_comb begin
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        data = 32'h0;
        case (mem_op)
            LW:      data = word;
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'h0, half_sel};
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'h0, byte_sel};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory stage of the 5-stage MIPS pipeline: word-organised data memory with
// byte/halfword store merging, load extraction/extension, and the M/W
// pipeline register. Every output is registered.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   ALU_Out_in_M      - byte address for loads/stores, ALU result otherwise
//   Data_to_dm_in_M   - store data (forwarded rt)
//   WriteReg_in_M     - destination register
//   Instr_in_M        - instruction word, opcode in [31:26]
//   PC4_in_M          - PC+4 of the instruction
//   *_out_M           - M/W register outputs; DM_Read_out_M is the load result
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_Out_in_M,
    input  logic [31:0] Data_to_dm_in_M,
    input  logic [4:0]  WriteReg_in_M,
    input  logic [31:0] Instr_in_M,
    input  logic [31:0] PC4_in_M,
    output logic [31:0] ALU_Out_out_M,
    output logic [31:0] DM_Read_out_M,
    output logic [4:0]  WriteReg_out_M,
    output logic [31:0] Instr_out_M,
    output logic [31:0] PC4_out_M
);

    logic [31:0]      dm [DM_WORDS];
    mem_op_t          op;
    logic [DM_AW-1:0] word_idx;
    logic [1:0]       addr_lo;
    logic [31:0]      rd_word;
    logic [31:0]      load_data;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data;

    assign op       = decode_mem_op(Instr_in_M[31:26]);
    // Upper address bits are dropped, so addresses wrap modulo 4*DM_WORDS.
    assign word_idx = ALU_Out_in_M[DM_AW+1:2];
    assign addr_lo  = ALU_Out_in_M[1:0];
    assign rd_word  = dm[word_idx];

    // Translate the store type into per-byte write enables with the data
    // replicated across lanes. Misaligned sw/sh produce no enables at all,
    // so the access is silently dropped rather than trapping.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = 32'h0;
        case (op)
            SW: begin
                if (addr_lo == 2'b00) begin
                    byte_en = 4'b1111;
                    wr_data = Data_to_dm_in_M;
                end
            end
            SH: begin
                if (!addr_lo[0]) begin
                    byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{Data_to_dm_in_M[15:0]}};
                end
            end
            SB: begin
                byte_en = 4'b0001 << addr_lo;
                wr_data = {4{Data_to_dm_in_M[7:0]}};
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = 32'h0;
            end
        endcase
    end

    // Data memory. Reset clears every word in one edge and takes priority
    // over any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm[DM_AW'(i)] <= 32'h0;
            end
        end else begin
            if (byte_en[0]) dm[word_idx][7:0]   <= wr_data[7:0];
            if (byte_en[1]) dm[word_idx][15:8]  <= wr_data[15:8];
            if (byte_en[2]) dm[word_idx][23:16] <= wr_data[23:16];
            if (byte_en[3]) dm[word_idx][31:24] <= wr_data[31:24];
        end
    end

    dm_ext u_dm_ext (
        .word    (rd_word),
        .addr_lo (addr_lo),
        .mem_op  (op),
        .data    (load_data)
    );

    // M/W pipeline register. No enable: stalls and bubbles come from
    // upstream, and reset makes the next stage see a nop.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALU_Out_out_M  <= 32'h0;
            DM_Read_out_M  <= 32'h0;
            WriteReg_out_M <= 5'h0;
            Instr_out_M    <= 32'h0;
            PC4_out_M      <= 32'h0;
        end else begin
            ALU_Out_out_M  <= ALU_Out_in_M;
            DM_Read_out_M  <= load_data;
            WriteReg_out_M <= WriteReg_in_M;
            Instr_out_M    <= Instr_in_M;
            PC4_out_M      <= PC4_in_M;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed testbench for mem_stage. Each step presents one instruction for
// one cycle and then checks the registered outputs just after the edge.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] ALU_Out_in_M;
    logic [31:0] Data_to_dm_in_M;
    logic [4:0]  WriteReg_in_M;
    logic [31:0] Instr_in_M;
    logic [31:0] PC4_in_M;
    logic [31:0] ALU_Out_out_M;
    logic [31:0] DM_Read_out_M;
    logic [4:0]  WriteReg_out_M;
    logic [31:0] Instr_out_M;
    logic [31:0] PC4_out_M;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ALU_Out_in_M    (ALU_Out_in_M),
        .Data_to_dm_in_M (Data_to_dm_in_M),
        .WriteReg_in_M   (WriteReg_in_M),
        .Instr_in_M      (Instr_in_M),
        .PC4_in_M        (PC4_in_M),
        .ALU_Out_out_M   (ALU_Out_out_M),
        .DM_Read_out_M   (DM_Read_out_M),
        .WriteReg_out_M  (WriteReg_out_M),
        .Instr_out_M     (Instr_out_M),
        .PC4_out_M       (PC4_out_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an I-type instruction word for a memory op (rs=1, rt=3).
    function automatic logic [31:0] instrFor(input mem_op_t op);
        logic [5:0] opc;
        case (op)
            LW:      opc = 6'b100011;
            LB:      opc = 6'b100000;
            LBU:     opc = 6'b100100;
            LH:      opc = 6'b100001;
            LHU:     opc = 6'b100101;
            SW:      opc = 6'b101011;
            SH:      opc = 6'b101001;
            SB:      opc = 6'b101000;
            default: opc = 6'b000000;
        endcase
        return {opc, 5'd1, 5'd3, 16'h0000};
    endfunction

    // Drive one instruction for a full cycle, then step to just past the edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] instr,
                                 input logic [31:0] addr, input logic [31:0] data);
        reset           = rst;
        Instr_in_M      = instr;
        ALU_Out_in_M    = addr;
        Data_to_dm_in_M = data;
        WriteReg_in_M   = 5'd3;
        PC4_in_M        = 32'h0000_0400;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic loadCheck(input string tag, input mem_op_t op,
                             input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b0, instrFor(op), addr, 32'h0);
        checkOutput(tag, DM_Read_out_M, expected);
    endtask

    task automatic storeOp(input mem_op_t op, input logic [31:0] addr,
                           input logic [31:0] data);
        applyStimulus(1'b0, instrFor(op), addr, data);
    endtask

    initial begin
        $display("[TB] starting mem_stage test");

        // Reset with junk on every input: all outputs must clear.
        applyStimulus(1'b1, instrFor(LW), 32'h0000_0010, 32'hFFFF_FFFF);
        checkOutput("rst_alu",   ALU_Out_out_M, 32'h0);
        checkOutput("rst_dm",    DM_Read_out_M, 32'h0);
        checkOutput("rst_wreg",  {27'h0, WriteReg_out_M}, 32'h0);
        checkOutput("rst_instr", Instr_out_M, 32'h0);
        checkOutput("rst_pc4",   PC4_out_M, 32'h0);

        // nop passes fields through with no load data.
        reset           = 1'b0;
        Instr_in_M      = 32'h0;
        ALU_Out_in_M    = 32'h0000_1234;
        Data_to_dm_in_M = 32'hCAFE_F00D;
        WriteReg_in_M   = 5'd7;
        PC4_in_M        = 32'h0000_0100;
        @(posedge clk);
        #1;
        checkOutput("nop_alu",   ALU_Out_out_M, 32'h0000_1234);
        checkOutput("nop_dm",    DM_Read_out_M, 32'h0);
        checkOutput("nop_wreg",  {27'h0, WriteReg_out_M}, 32'd7);
        checkOutput("nop_instr", Instr_out_M, 32'h0);
        checkOutput("nop_pc4",   PC4_out_M, 32'h0000_0100);
        loadCheck("lw_0x48_cleared", LW, 32'h48, 32'h0);

        // Full-word store then load.
        storeOp(SW, 32'h10, 32'h8BAD_F00D);
        checkOutput("sw_dm_zero",  DM_Read_out_M, 32'h0);
        checkOutput("sw_instr",    Instr_out_M, instrFor(SW));
        loadCheck("lw_0x10", LW, 32'h10, 32'h8BAD_F00D);

        // Byte merge and byte extraction.
        storeOp(SB, 32'h11, 32'h1234_56AA);
        loadCheck("lw_after_sb",  LW,  32'h10, 32'h8BAD_AA0D);
        loadCheck("lb_0x13",      LB,  32'h13, 32'hFFFF_FF8B);
        loadCheck("lbu_0x13",     LBU, 32'h13, 32'h0000_008B);
        loadCheck("lb_0x11",      LB,  32'h11, 32'hFFFF_FFAA);
        loadCheck("lbu_0x10",     LBU, 32'h10, 32'h0000_000D);
        loadCheck("lb_0x10_pos",  LB,  32'h10, 32'h0000_000D);
        loadCheck("lw_0x13_low",  LW,  32'h13, 32'h8BAD_AA0D);

        // Halfword merge and extraction.
        storeOp(SH, 32'h16, 32'hABCD_7FF0);
        loadCheck("lh_0x16",      LH,  32'h16, 32'h0000_7FF0);
        storeOp(SH, 32'h14, 32'h0000_8001);
        loadCheck("lh_0x14",      LH,  32'h14, 32'hFFFF_8001);
        loadCheck("lhu_0x14",     LHU, 32'h14, 32'h0000_8001);
        loadCheck("lw_0x14",      LW,  32'h14, 32'h7FF0_8001);
        loadCheck("lhu_0x16",     LHU, 32'h16, 32'h0000_7FF0);

        // Misaligned halfword store is dropped.
        storeOp(SH, 32'h15, 32'h0000_FFFF);
        loadCheck("lw_after_bad_sh", LW, 32'h14, 32'h7FF0_8001);

        // Misaligned word store is dropped.
        storeOp(SW, 32'h21, 32'hDEAD_BEEF);
        loadCheck("lw_after_bad_sw", LW, 32'h20, 32'h0);

        // Address wrap modulo 4*DM_WORDS.
        storeOp(SW, 32'h1000, 32'h0000_0055);
        loadCheck("lw_wrap_0x0",    LW, 32'h0,    32'h0000_0055);
        loadCheck("lw_wrap_0x1000", LW, 32'h1000, 32'h0000_0055);

        // Non-memory instruction (add) whose ALU result looks like an address.
        applyStimulus(1'b0, 32'h0022_1820, 32'h10, 32'hFFFF_FFFF);
        checkOutput("alu_op_dm",  DM_Read_out_M, 32'h0);
        checkOutput("alu_op_alu", ALU_Out_out_M, 32'h10);
        loadCheck("lw_0x10_unchanged", LW, 32'h10, 32'h8BAD_AA0D);

        // Reset mid-stream with a store in the same cycle.
        applyStimulus(1'b1, instrFor(SW), 32'h4, 32'h1);
        checkOutput("mid_rst_alu",   ALU_Out_out_M, 32'h0);
        checkOutput("mid_rst_dm",    DM_Read_out_M, 32'h0);
        checkOutput("mid_rst_instr", Instr_out_M, 32'h0);
        checkOutput("mid_rst_pc4",   PC4_out_M, 32'h0);
        checkOutput("mid_rst_wreg",  {27'h0, WriteReg_out_M}, 32'h0);
        loadCheck("lw_0x4_after_rst",  LW, 32'h4,  32'h0);
        loadCheck("lw_0x10_after_rst", LW, 32'h10, 32'h0);
        loadCheck("lw_0x0_after_rst",  LW, 32'h0,  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
